multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle sequencer for the 16-bit CPU datapath: decodes op/funct and drives its control strobes state by state.
//  Owns the single shared memory port via a req/ready handshake, used for both instruction fetch and data access.
//  Sits between the top-level CPU wrapper and the datapath; replaces the combinational controller.
// PARAMETERS
//  OPW      4   opcode width (instr[15:12])
//  TIMEOUT  15  max wait cycles for mem_ready before fault (used only with MC_MEM_TIMEOUT_EN)
// PORTS
//  clk         in   1    rising-edge clock
//  reset       in   1    asynchronous, active-low reset
//  run         in   1    start pulse; leaves IDLE/HALT
//  op          in   OPW  opcode from instruction register
//  funct       in   3    R-type function field
//  zero        in   1    ALU zero flag
//  mem_ready   in   1    memory accepts/returns this cycle
//  mem_req     out  1    memory request, held until mem_ready
//  mem_we      out  1    write qualifier for mem_req
//  iord        out  1    address select: 0=pc, 1=aluout
//  irwrite     out  1    latch instruction register
//  pcwrite     out  1    load PC
//  pcsrc,jump  out  1,1  next-PC selects (branch, jump)
//  regwrite    out  1    register file write enable
//  memtoreg, alusrc, regdst  out 1 each  datapath mux selects
//  alucontrol  out  4    ALU operation
//  halted      out  1    high in HALT
//  fault       out  1    high in FAULT (tied 0 without macro)
// BEHAVIOUR
//  - reset low: state=IDLE, every output 0, wait counter 0; an in-flight mem_req drops asynchronously.
//  - States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIWB, BRANCH, JUMP, HALT, FAULT.
//  - IDLE/HALT -> FETCH when run=1; run ignored in all other states.
//  - FETCH: mem_req=1, iord=0, alusrc/alucontrol=ADD for pc+2.
//    When mem_ready=1 that cycle: irwrite=1 and pcwrite=1 (Mealy), then DECODE. Otherwise remain in FETCH.
//  - DECODE, one cycle. Next state by op:
//    0000 R -> EXEC; 0001 LW / 0010 SW -> MEMADR; 0011 BEQ -> BRANCH; 0100 ADDI -> EXEC;
//    0101 J -> JUMP; 1111 HALT -> HALT; any other op -> FETCH (NOP).
//  - MEMADR: alusrc=1, alucontrol=ADD, one cycle; LW -> MEMRD, SW -> MEMWR.
//  - MEMRD/MEMWR: mem_req=1, iord=1, mem_we=1 in MEMWR only, held stable until mem_ready.
//    MEMRD+ready -> MEMWB; MEMWR+ready -> FETCH.
//  - MEMWB: regwrite=1, memtoreg=1, regdst=0; -> FETCH.
//  - EXEC: R uses the funct map; ADDI uses alusrc=1, ADD. Then -> ALUWB (R, regdst=1) or ADDIWB (regdst=0), regwrite=1, -> FETCH.
//  - BRANCH: alucontrol=SUB, pcsrc=1, pcwrite=zero; -> FETCH.
//  - JUMP: jump=1, pcwrite=1; -> FETCH.
//  - funct map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT; other values give ADD.
//  - Latencies: R/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3. Each memory state adds its wait cycles.
//  - Outputs not listed for a state are 0. mem_req never deasserts before ready, except on reset.
// CONFIGURATION
//  MC_MEM_TIMEOUT_EN defined:
//    - A 4-bit wait counter runs while mem_req=1 and mem_ready=0.
//    - If the count reaches TIMEOUT -> FAULT: outputs 0, fault=1. Only reset exits FAULT.
//    - The counter clears on every ready cycle and on every state change.
//  MC_MEM_TIMEOUT_EN undefined: no counter, fault tied 0, memory states wait indefinitely.
// STRUCTURE
//  - Shared package cpu_ctrl_pkg holds:
//    state_t enum; opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT);
//    ALU codes ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
//  - One sub-module, alu_decoder: funct -> alucontrol, purely combinational.
//  - State register, next-state logic and output logic stay in this module.
// TESTING
//  1. reset low mid-FETCH with mem_req=1 -> mem_req=0 immediately; after release, state IDLE, all outputs 0.
//  2. run=1, op=0000, funct=001, mem_ready=1 -> FETCH(irwrite,pcwrite), DECODE, EXEC(alucontrol=0110),
//     ALUWB(regwrite=1, regdst=1): 4 cycles.
//  3. op=0001 with mem_ready low 3 cycles in MEMRD -> mem_req/iord held for 4 cycles; MEMWB asserts regwrite, memtoreg.
//  4. op=0011 with zero=0 -> pcwrite=0; with zero=1 -> pcwrite=1, pcsrc=1. Both return to FETCH.
//  5. op=1111 -> halted=1, outputs 0 while run=0; run=1 -> FETCH next cycle.
//  6. [MC_MEM_TIMEOUT_EN] mem_ready held 0 in FETCH for 15 cycles -> fault=1, mem_req=0; stays until reset.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode and ALU code definitions for the multicycle controller
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational R-type funct to ALU operation decode
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] funct,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (funct)
      3'b000:  alucontrol = ALU_ADD;
      3'b001:  alucontrol = ALU_SUB;
      3'b010:  alucontrol = ALU_AND;
      3'b011:  alucontrol = ALU_OR;
      3'b100:  alucontrol = ALU_SLT;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU sequencer owning the shared memory port
// Optional memory wait timeout enabled by defining MC_MEM_TIMEOUT_EN.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] op,
  input  logic [2:0]     funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           pcsrc,
  output logic           jump,
  output logic           regwrite,
  output logic           memtoreg,
  output logic           alusrc,
  output logic           regdst,
  output logic [3:0]     alucontrol,
  output logic           halted,
  output logic           fault
);

  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("multicycle_ctrl: TIMEOUT must be in 1..15");
  end

  state_t     state;
  state_t     nxt;
  logic [3:0] funct_alu;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alucontrol (funct_alu)
  );

`ifdef MC_MEM_TIMEOUT_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT - 1);
  logic [3:0] wait_cnt;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_HALT: if (run) nxt = S_FETCH;
      S_FETCH:        if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_R, OP_ADDI: nxt = S_EXEC;
          OP_LW, OP_SW:  nxt = S_MEMADR;
          OP_BEQ:        nxt = S_BRANCH;
          OP_J:          nxt = S_JUMP;
          OP_HALT:       nxt = S_HALT;
          default:       nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = (op == OP_R) ? S_ALUWB : S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
`ifdef MC_MEM_TIMEOUT_EN
    // The request would otherwise be held forever; abandon it on the last allowed wait.
    if (mem_req && !mem_ready && wait_cnt == WAIT_LIMIT) nxt = S_FAULT;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

`ifdef MC_MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    wait_cnt <= '0;
    else if (nxt != state || mem_ready || !mem_req) wait_cnt <= '0;
    else                                           wait_cnt <= wait_cnt + 4'd1;
  end
`endif

  // Decoded from the state register so an async reset drops mem_req at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    alucontrol = 4'b0000;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alucontrol = ALU_ADD;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
      end
      S_MEMADR: begin
        alusrc     = 1'b1;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_EXEC: begin
        if (op == OP_R) begin
          alucontrol = funct_alu;
        end else begin
          alusrc     = 1'b1;
          alucontrol = ALU_ADD;
        end
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_BRANCH: begin
        alucontrol = ALU_SUB;
        pcsrc      = 1'b1;
        pcwrite    = zero;
      end
      S_JUMP: begin
        jump    = 1'b1;
        pcwrite = 1'b1;
      end
      S_HALT: halted = 1'b1;
`ifdef MC_MEM_TIMEOUT_EN
      S_FAULT: fault = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with a per-instruction reference model
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       jump;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic [3:0] alucontrol;
    logic       halted;
    logic       fault;
  } ctl_t;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] op;
  logic [2:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, jump;
  logic       regwrite, memtoreg, alusrc, regdst, halted, fault;
  logic [3:0] alucontrol;

  int compared   = 0;
  int mismatched = 0;

  ctl_t       exp_q[$];
  string      tag_q[$];
  logic [3:0] fmap[8];

  multicycle_ctrl #(.OPW(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .alucontrol (alucontrol),
    .halted     (halted),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t actual();
    return {mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, jump, regwrite,
            memtoreg, alusrc, regdst, alucontrol, halted, fault};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Monitor: one expected control word per clock, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      ctl_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual();
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL %s @%0t: got %b required %b", t, $time, a, e);
      end
    end
  end

  task automatic check_now(input string t, input ctl_t e);
    ctl_t a;
    a = actual();
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s @%0t: got %b required %b", t, $time, a, e);
    end
  endtask

  task automatic step(input ctl_t e, input logic r, input logic rdy, input logic z, input string t);
    run       = r;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int fw);
    ctl_t e;
    e = '0;
    e.mem_req    = 1'b1;
    e.alucontrol = A_ADD;
    for (int i = 0; i < fw; i++) step(e, rb(), 1'b0, rb(), "fetch_wait");
    e.irwrite = 1'b1;
    e.pcwrite = 1'b1;
    step(e, rb(), 1'b1, rb(), "fetch_ready");
  endtask

  // Reference model: expected control words for one whole instruction, starting in FETCH.
  task automatic do_instr(input logic [3:0] o, input logic [2:0] f, input int fw,
                          input int mw, input logic z, input int hold);
    ctl_t e;
    op    = o;
    funct = f;
    fetch(fw);
    step('0, rb(), rb(), rb(), "decode");
    e = '0;
    case (o)
      4'b0000: begin
        e.alucontrol = fmap[f];
        step(e, rb(), rb(), rb(), "exec_r");
        e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
        step(e, rb(), rb(), rb(), "aluwb");
      end
      4'b0100: begin
        e.alusrc = 1'b1; e.alucontrol = A_ADD;
        step(e, rb(), rb(), rb(), "exec_addi");
        e = '0; e.regwrite = 1'b1;
        step(e, rb(), rb(), rb(), "addiwb");
      end
      4'b0001, 4'b0010: begin
        e.alusrc = 1'b1; e.alucontrol = A_ADD;
        step(e, rb(), rb(), rb(), "memadr");
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (o == 4'b0010);
        for (int i = 0; i < mw; i++) step(e, rb(), 1'b0, rb(), "mem_wait");
        step(e, rb(), 1'b1, rb(), "mem_ready");
        if (o == 4'b0001) begin
          e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
          step(e, rb(), rb(), rb(), "memwb");
        end
      end
      4'b0011: begin
        e.alucontrol = A_SUB; e.pcsrc = 1'b1; e.pcwrite = z;
        step(e, rb(), rb(), z, "branch");
      end
      4'b0101: begin
        e.jump = 1'b1; e.pcwrite = 1'b1;
        step(e, rb(), rb(), rb(), "jump");
      end
      4'b1111: begin
        e.halted = 1'b1;
        for (int i = 0; i < hold; i++) step(e, 1'b0, rb(), rb(), "halt_hold");
        step(e, 1'b1, rb(), rb(), "halt_run");
      end
      default: ;
    endcase
  endtask

  task automatic reset_to_idle();
    reset = 1'b0;
    #1;
    check_now("reset_async_outputs", '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step('0, 1'b0, rb(), rb(), "post_reset_idle");
    step('0, 1'b0, rb(), rb(), "post_reset_idle");
    step('0, 1'b1, rb(), rb(), "idle_run");
  endtask

  initial begin
    ctl_t e;
    fmap = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_ADD, A_ADD, A_ADD};
    reset = 1'b0; run = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_outputs", '0);
    reset = 1'b1;
    step('0, 1'b0, 1'b1, 1'b1, "idle");
    step('0, 1'b0, 1'b0, 1'b0, "idle");
    step('0, 1'b1, 1'b0, 1'b0, "idle_run");
    fetch(0);
    op = 4'b1110;
    step('0, 1'b0, 1'b0, 1'b0, "decode_nop");

    // Abort an outstanding fetch with reset and confirm the request drops immediately.
    e = '0; e.mem_req = 1'b1; e.alucontrol = A_ADD;
    step(e, 1'b0, 1'b0, 1'b0, "fetch_wait_pre_reset");
    #1;
    check_now("fetch_req_before_reset", e);
    reset_to_idle();

    do_instr(4'b0000, 3'b001, 0, 0, 1'b0, 0);
    do_instr(4'b0001, 3'b000, 1, 3, 1'b0, 0);
    do_instr(4'b0011, 3'b000, 0, 0, 1'b0, 0);
    do_instr(4'b0011, 3'b000, 2, 0, 1'b1, 0);
    do_instr(4'b0010, 3'b000, 0, 2, 1'b0, 0);
    do_instr(4'b0100, 3'b011, 0, 0, 1'b0, 0);
    do_instr(4'b0101, 3'b000, 0, 0, 1'b0, 0);
    do_instr(4'b1111, 3'b000, 0, 0, 1'b0, 3);
    do_instr(4'b0111, 3'b000, 1, 0, 1'b0, 0);
    for (int f = 0; f < 8; f++) do_instr(4'b0000, 3'(f), 0, 0, 1'b0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0] o;
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: o = 4'b0000;
        1: o = 4'b0001;
        2: o = 4'b0010;
        3: o = 4'b0011;
        4: o = 4'b0100;
        5: o = 4'b0101;
        6: o = 4'b1111;
        default: o = 4'($urandom_range(6, 14));
      endcase
      do_instr(o, 3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 4),
               rb(), $urandom_range(0, 3));
    end

`ifdef MC_MEM_TIMEOUT_EN
    do_instr(4'b0001, 3'b000, 14, 14, 1'b0, 0);
    e = '0; e.mem_req = 1'b1; e.alucontrol = A_ADD;
    for (int i = 0; i < 15; i++) step(e, 1'b0, 1'b0, rb(), "timeout_wait");
    e = '0; e.fault = 1'b1;
    for (int i = 0; i < 4; i++) step(e, 1'b1, rb(), rb(), "fault_sticky");
    reset_to_idle();
    do_instr(4'b0101, 3'b000, 0, 0, 1'b0, 0);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drained: got %0d left required 0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
